vid_timing_gen: RTL and testbench
=================================

// Module: vid_timing_gen
// PURPOSE
//  Video source for the pixel clock domain: generates VESA-style raster timing
//  (vde/hsync/vsync) and a selectable 24-bit test pattern on the same pixel
//  bus that img_proc consumes. Used as the transmit end of that bus.
//  It drives rgb2vga_ip or img_proc when there is no HDMI input, and it
//  stimulates the image pipeline during bring-up.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   hsync width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync width (lines)
//  V_BP       33   vertical back porch (lines)
//  SYNC_POL   0    sync active level (0 = active-low, 1 = active-high), applies to both syncs
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  en           in   1   run enable
//  sw           in   4   pattern select: [1:0] pattern, [2] invert, [3] reserved (ignored)
//  data_o       out  24  pixel {R[23:16], B[15:8], G[7:0]} (dvi2rgb/img_proc byte order)
//  vde_o        out  1   active video
//  hsync_o      out  1   horizontal sync, level per SYNC_POL
//  vsync_o      out  1   vertical sync, level per SYNC_POL
//  frame_start_o out 1   1-cycle pulse coincident with first active pixel (h=0,v=0)
//  frame_cnt_o  out  16  completed-frame count, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (async assert, synchronous release): h_cnt=v_cnt=0, data_o=0, vde_o=0,
//    frame_start_o=0, frame_cnt_o=0, syncs inactive (~SYNC_POL), pattern reg=0.
//  - Raster: h_cnt 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800);
//    v_cnt advances when h_cnt wraps, 0..V_TOTAL-1 (525); both wrap to 0.
//  - Regions (on counters): active h<H_ACTIVE && v<V_ACTIVE;
//    hsync when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync for lines in the
//    same form with V_*; vsync changes on the h_cnt=0 boundary.
//  - Latency: all outputs registered; output at cycle n+1 reflects counters at cycle n.
//    vde/hsync/vsync/data stay mutually aligned (no skew).
//  - Pattern (sw[1:0], sampled into a pattern reg only at h=0,v=0, so there is
//    never a mid-frame change):
//    0 colour bars: 8 bars of width H_ACTIVE/8, order white,yellow,cyan,green,
//      magenta,red,blue,black; each channel is 0xFF or 0x00
//    1 solid grey 0x808080
//    2 horizontal ramp: R=G=B=h_cnt[7:0]
//    3 checkerboard: white when h_cnt[5]^v_cnt[5] is 1, else black
//    sw[2]=1 -> data = ~pattern. data_o=0 whenever vde_o=0.
//  - frame_cnt_o increments on the cycle the counters wrap (h=H_TOTAL-1,
//    v=V_TOTAL-1).
//  - en low: counters held at 0, vde_o=0, syncs inactive, data_o=0, frame_cnt held.
//    en rising: raster restarts at h=0,v=0 and frame_start_o pulses 1 cycle later.
//    en falling mid-frame: raster aborts immediately; the frame is not counted.
//  - Asynchronous reset mid-frame: outputs return to reset values immediately.
// CONFIGURATION
//  VTG_CROSSHAIR_EN defined: in active video, pixels with h==H_ACTIVE/2 or
//    v==V_ACTIVE/2 are forced to 0xFFFFFF. The crosshair is applied after sw[2]
//    inversion, so it is unaffected by invert. Latency is unchanged.
//  Not defined: no overlay logic; data is the pure pattern.
// TESTING
//  1 Reset with en=1 -> first frame: each line has exactly 640 vde cycles, 800 cycles
//    per line, 525 lines; hsync low for 96 cycles starting 656 cycles after line vde rise.
//  2 sw=0 -> data_o=0xFFFFFF for h 0..79, then 0xFF00FF (yellow, RBG order) for h 80..159,
//    ..., 0x000000 for h 560..639; the same on every active line.
//  3 sw changed 0->3 mid-frame -> the current frame stays as bars; the next frame is a
//    checkerboard (pixel(32,0)=0xFFFFFF, pixel(32,32)=0).
//  4 sw=6 (ramp, invert) -> data_o at h=0x10 equals 0xEFEFEF; data_o=0 during blanking.
//  5 en dropped at v=100 and raised 50 cycles later -> outputs idle while en is low;
//    frame_start_o pulses 1 cycle after the rise; frame_cnt unchanged by the aborted frame.
//  6 VTG_CROSSHAIR_EN defined, sw=1 -> pixel(320,y) and pixel(x,240) are 0xFFFFFF;
//    all other active pixels are 0x808080.

Source files
------------

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: VESA-style raster timing (vde/hsync/vsync) plus a selectable
// 24-bit test pattern on the {R,B,G} pixel bus. All outputs are registered one
// cycle behind the raster counters.
// Optional build macro: VTG_CROSSHAIR_EN forces a white crosshair through the
// centre of the active area. The crosshair is applied after inversion.
module vid_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  sw,
    output logic [23:0] data_o,
    output logic        vde_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_start_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned BAR_W    = H_ACTIVE / 8;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [2:0]    pat_q;

    logic          h_last_c;
    logic          v_last_c;
    logic          origin_c;
    logic [2:0]    pat_sel_c;
    logic          active_c;
    logic          hs_c;
    logic          vs_c;
    logic [2:0]    bar_c;
    logic          chk_c;
    logic [7:0]    ramp_c;
    logic [23:0]   pix_c;
    logic [HW-1:0] h_nxt_c;
    logic [VW-1:0] v_nxt_c;

    // sw[3] is reserved and deliberately ignored
    logic unused_sw;
    assign unused_sw = sw[3];

    // Raster decode and pixel generation from the current counter position
    always_comb begin
        h_last_c  = (h_cnt == HW'(H_TOTAL - 1));
        v_last_c  = (v_cnt == VW'(V_TOTAL - 1));
        origin_c  = (h_cnt == '0) && (v_cnt == '0);
        // A new selection takes effect from the very first pixel of the frame
        pat_sel_c = origin_c ? sw[2:0] : pat_q;
        active_c  = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        hs_c      = (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END));
        vs_c      = (v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END));
        bar_c     = 3'(32'(h_cnt) / BAR_W);
        chk_c     = 1'((32'(h_cnt) ^ 32'(v_cnt)) >> 5);
        ramp_c    = 8'(h_cnt);
        h_nxt_c   = h_last_c ? '0 : h_cnt + HW'(1);
        v_nxt_c   = v_cnt;
        if (h_last_c) begin
            v_nxt_c = v_last_c ? '0 : v_cnt + VW'(1);
        end

        pix_c = 24'h000000;
        case (pat_sel_c[1:0])
            2'd0: begin
                case (bar_c)
                    3'd0:    pix_c = 24'hFFFFFF; // white
                    3'd1:    pix_c = 24'hFF00FF; // yellow
                    3'd2:    pix_c = 24'h00FFFF; // cyan
                    3'd3:    pix_c = 24'h0000FF; // green
                    3'd4:    pix_c = 24'hFFFF00; // magenta
                    3'd5:    pix_c = 24'hFF0000; // red
                    3'd6:    pix_c = 24'h00FF00; // blue
                    default: pix_c = 24'h000000; // black
                endcase
            end
            2'd1:    pix_c = 24'h808080;
            2'd2:    pix_c = {ramp_c, ramp_c, ramp_c};
            default: pix_c = chk_c ? 24'hFFFFFF : 24'h000000;
        endcase
        if (pat_sel_c[2]) begin
            pix_c = ~pix_c;
        end
`ifdef VTG_CROSSHAIR_EN
        if ((h_cnt == HW'(H_ACTIVE / 2)) || (v_cnt == VW'(V_ACTIVE / 2))) begin
            pix_c = 24'hFFFFFF;
        end
`endif
        if (!active_c) begin
            pix_c = 24'h000000;
        end
    end

    // Counters, pattern register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            pat_q         <= '0;
            data_o        <= '0;
            vde_o         <= 1'b0;
            hsync_o       <= ~SYNC_POL;
            vsync_o       <= ~SYNC_POL;
            frame_start_o <= 1'b0;
            frame_cnt_o   <= '0;
        end else if (!en) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            data_o        <= '0;
            vde_o         <= 1'b0;
            hsync_o       <= ~SYNC_POL;
            vsync_o       <= ~SYNC_POL;
            frame_start_o <= 1'b0;
        end else begin
            h_cnt         <= h_nxt_c;
            v_cnt         <= v_nxt_c;
            pat_q         <= pat_sel_c;
            data_o        <= pix_c;
            vde_o         <= active_c;
            hsync_o       <= hs_c ? SYNC_POL : ~SYNC_POL;
            vsync_o       <= vs_c ? SYNC_POL : ~SYNC_POL;
            frame_start_o <= origin_c;
            if (h_last_c && v_last_c) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen on a reduced raster (80x47 total) so full frames
// fit in a short run. A frame-position model predicts every output cycle.
module tb_vid_timing_gen;

    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int HS  = 8;
    localparam int HBP = 4;
    localparam int VA  = 40;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam bit SP  = 1'b0;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  sw;
    logic [23:0] data_o;
    logic        vde_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        frame_start_o;
    logic [15:0] frame_cnt_o;

    int vecs  = 0;
    int fails = 0;

    // model state: linear position in frame of the next pixel to be emitted
    int          pos;
    logic [2:0]  m_pat;
    logic [15:0] m_fcnt;
    int          m_h;
    int          m_v;
    logic [23:0] e_data;
    logic        e_vde;
    logic        e_hs;
    logic        e_vs;
    logic        e_fs;

    logic [23:0] bar_rbg [8] = '{24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
                                 24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000};

    wire [43:0] dut_bus = {data_o, vde_o, hsync_o, vsync_o, frame_start_o, frame_cnt_o};
    wire [43:0] exp_bus = {e_data, e_vde, e_hs, e_vs, e_fs, m_fcnt};

    vid_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_POL (SP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .sw            (sw),
        .data_o        (data_o),
        .vde_o         (vde_o),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .frame_start_o (frame_start_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pix(int h, int v, logic [2:0] sel);
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [23:0] p;
        int          bar;
        bar = h / (HA / 8);
        r = 8'h00; g = 8'h00; b = 8'h00;
        case (sel[1:0])
            2'd0: begin
                r = (bar inside {0, 1, 4, 5}) ? 8'hFF : 8'h00;
                g = (bar inside {0, 1, 2, 3}) ? 8'hFF : 8'h00;
                b = (bar inside {0, 2, 4, 6}) ? 8'hFF : 8'h00;
            end
            2'd1: begin r = 8'h80; g = 8'h80; b = 8'h80; end
            2'd2: begin r = 8'(h % 256); g = r; b = r; end
            default: begin
                r = (((h / 32) % 2) != ((v / 32) % 2)) ? 8'hFF : 8'h00;
                g = r; b = r;
            end
        endcase
        p = {r, b, g};
        if (sel[2]) p = ~p;
`ifdef VTG_CROSSHAIR_EN
        if (h == HA / 2 || v == VA / 2) p = 24'hFFFFFF;
`endif
        return p;
    endfunction

    task automatic model_reset();
        pos = 0; m_pat = 3'd0; m_fcnt = 16'd0; m_h = -1; m_v = -1;
        e_data = 24'h0; e_vde = 1'b0; e_hs = ~SP; e_vs = ~SP; e_fs = 1'b0;
    endtask

    // predict outputs for the coming edge, then advance one clock
    task automatic tick();
        int h;
        int v;
        if (en) begin
            h = pos % HT;
            v = pos / HT;
            if (pos == 0) m_pat = sw[2:0];
            e_vde  = (h < HA) && (v < VA);
            e_hs   = (h >= HA + HFP && h < HA + HFP + HS) ? SP : ~SP;
            e_vs   = (v >= VA + VFP && v < VA + VFP + VS) ? SP : ~SP;
            e_data = e_vde ? pix(h, v, m_pat) : 24'h0;
            e_fs   = (pos == 0);
            if (pos == FT - 1) m_fcnt = m_fcnt + 16'd1;
            pos = (pos + 1) % FT;
            m_h = h; m_v = v;
        end else begin
            pos = 0; e_data = 24'h0; e_vde = 1'b0; e_hs = ~SP; e_vs = ~SP; e_fs = 1'b0;
            m_h = -1; m_v = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; sw = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vecs++; if (data_o !== 24'h0) begin fails++; $display("FAIL reset_data got=%h exp=000000", data_o); end
        vecs++; if (vde_o !== 1'b0) begin fails++; $display("FAIL reset_vde got=%b exp=0", vde_o); end
        vecs++; if ({hsync_o, vsync_o} !== {~SP, ~SP}) begin fails++; $display("FAIL reset_syncs got=%b%b exp=%b%b", hsync_o, vsync_o, ~SP, ~SP); end
        vecs++; if ({frame_start_o, frame_cnt_o} !== 17'h0) begin fails++; $display("FAIL reset_frame got=%b/%h exp=0/0000", frame_start_o, frame_cnt_o); end
        en = 1'b1;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_bars_timing();
        bit p_vde = 1'b0;
        bit p_hs  = ~SP;
        bit line_seen = 1'b0;
        int since = 0, vde_len = 0, hs_len = 0, lines = 0;
        sw = 4'd0;
        for (int n = 0; n < FT + HT; n++) begin
            tick();
            vecs++; if (dut_bus !== exp_bus) begin fails++; $display("FAIL bars_cycle h=%0d v=%0d got=%h exp=%h", m_h, m_v, dut_bus, exp_bus); end
            if (m_v == 3 && m_h >= 0 && m_h < HA && (m_h % 8) == 3) begin
                vecs++; if (data_o !== bar_rbg[m_h / 8]) begin fails++; $display("FAIL bar_colour h=%0d got=%h exp=%h", m_h, data_o, bar_rbg[m_h / 8]); end
            end
            if (vde_o && !p_vde) begin since = 0; vde_len = 0; line_seen = 1'b1; if (n < FT) lines++; end
            else since++;
            if (vde_o) vde_len++;
            if (!vde_o && p_vde) begin
                vecs++; if (vde_len != HA) begin fails++; $display("FAIL vde_width got=%0d exp=%0d", vde_len, HA); end
            end
            if (hsync_o == SP && p_hs != SP) begin
                hs_len = 0;
                if (line_seen) begin
                    vecs++; if (since != HA + HFP) begin fails++; $display("FAIL hsync_offset got=%0d exp=%0d", since, HA + HFP); end
                    line_seen = 1'b0;
                end
            end
            if (hsync_o == SP) hs_len++;
            if (hsync_o != SP && p_hs == SP) begin
                vecs++; if (hs_len != HS) begin fails++; $display("FAIL hsync_width got=%0d exp=%0d", hs_len, HS); end
            end
            p_vde = vde_o; p_hs = hsync_o;
        end
        vecs++; if (lines != VA) begin fails++; $display("FAIL active_lines got=%0d exp=%0d", lines, VA); end
        vecs++; if (frame_cnt_o !== 16'd1) begin fails++; $display("FAIL first_frame_count got=%0d exp=1", frame_cnt_o); end
    endtask

    task automatic test_pattern_switch();
        int  guard = 0;
        bit  seen = 1'b0;
        while (!(m_v == 5 && m_h == 0) && guard < 2 * FT) begin
            tick(); guard++;
            vecs++; if (dut_bus !== exp_bus) begin fails++; $display("FAIL switch_pre h=%0d v=%0d got=%h exp=%h", m_h, m_v, dut_bus, exp_bus); end
        end
        vecs++; if (guard >= 2 * FT) begin fails++; $display("FAIL switch_reach got=timeout exp=v5"); end
        sw = 4'd3;
        for (int n = 0; n < FT + 34 * HT; n++) begin
            tick();
            if (e_fs) seen = 1'b1;
            vecs++; if (dut_bus !== exp_bus) begin fails++; $display("FAIL switch_cycle h=%0d v=%0d got=%h exp=%h", m_h, m_v, dut_bus, exp_bus); end
            if (!seen && m_v == 10 && m_h == 8) begin
                vecs++; if (data_o !== 24'hFF00FF) begin fails++; $display("FAIL switch_old_frame got=%h exp=ff00ff", data_o); end
            end
            if (seen && m_v == 0 && m_h == 32) begin
                vecs++; if (data_o !== 24'hFFFFFF) begin fails++; $display("FAIL checker_32_0 got=%h exp=ffffff", data_o); end
            end
            if (seen && m_v == 32 && m_h == 32) begin
                vecs++; if (data_o !== 24'h000000) begin fails++; $display("FAIL checker_32_32 got=%h exp=000000", data_o); end
            end
        end
    endtask

    task automatic test_ramp_invert();
        bit seen = 1'b0;
        sw = 4'd6;
        for (int n = 0; n < 2 * FT; n++) begin
            tick();
            if (e_fs) seen = 1'b1;
            vecs++; if (dut_bus !== exp_bus) begin fails++; $display("FAIL ramp_cycle h=%0d v=%0d got=%h exp=%h", m_h, m_v, dut_bus, exp_bus); end
            if (seen && m_v == 1 && m_h == 16) begin
                vecs++; if (data_o !== 24'hEFEFEF) begin fails++; $display("FAIL ramp_inv_h16 got=%h exp=efefef", data_o); end
            end
            if (seen && m_v == 1 && m_h == HA + 2) begin
                vecs++; if (data_o !== 24'h000000) begin fails++; $display("FAIL ramp_blank got=%h exp=000000", data_o); end
            end
        end
    endtask

    task automatic test_en_abort();
        int          guard = 0;
        logic [15:0] saved;
        sw = 4'd0;
        while (!(m_v == 10 && m_h == 20) && guard < 2 * FT) begin
            tick(); guard++;
            vecs++; if (dut_bus !== exp_bus) begin fails++; $display("FAIL abort_pre h=%0d v=%0d got=%h exp=%h", m_h, m_v, dut_bus, exp_bus); end
        end
        vecs++; if (guard >= 2 * FT) begin fails++; $display("FAIL abort_reach got=timeout exp=v10"); end
        saved = frame_cnt_o;
        en = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            vecs++; if (dut_bus !== exp_bus) begin fails++; $display("FAIL abort_idle_cycle n=%0d got=%h exp=%h", n, dut_bus, exp_bus); end
            vecs++; if ({vde_o, data_o, hsync_o, vsync_o} !== {1'b0, 24'h0, ~SP, ~SP}) begin fails++; $display("FAIL abort_idle n=%0d got=%b/%h/%b%b exp=0/000000/%b%b", n, vde_o, data_o, hsync_o, vsync_o, ~SP, ~SP); end
        end
        en = 1'b1;
        tick();
        vecs++; if (frame_start_o !== 1'b1) begin fails++; $display("FAIL restart_frame_start got=%b exp=1", frame_start_o); end
        vecs++; if (frame_cnt_o !== saved) begin fails++; $display("FAIL abort_frame_count got=%0d exp=%0d", frame_cnt_o, saved); end
        for (int n = 0; n < FT; n++) begin
            tick();
            vecs++; if (dut_bus !== exp_bus) begin fails++; $display("FAIL abort_post h=%0d v=%0d got=%h exp=%h", m_h, m_v, dut_bus, exp_bus); end
        end
        vecs++; if (frame_cnt_o !== saved + 16'd1) begin fails++; $display("FAIL resumed_frame_count got=%0d exp=%0d", frame_cnt_o, saved + 16'd1); end
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 123; n++) tick();
        #3 rst_n = 1'b0;
        #1;
        vecs++; if ({data_o, vde_o, hsync_o, vsync_o, frame_start_o, frame_cnt_o} !== {24'h0, 1'b0, ~SP, ~SP, 1'b0, 16'h0}) begin
            fails++; $display("FAIL async_reset got=%h exp=%h", dut_bus, {24'h0, 1'b0, ~SP, ~SP, 1'b0, 16'h0});
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int n = 0; n < 3 * HT; n++) begin
            tick();
            vecs++; if (dut_bus !== exp_bus) begin fails++; $display("FAIL post_reset h=%0d v=%0d got=%h exp=%h", m_h, m_v, dut_bus, exp_bus); end
        end
    endtask

    task automatic test_random();
        int low_left = 0;
        for (int n = 0; n < 3 * FT; n++) begin
            if ($urandom_range(0, 499) == 0) sw = 4'($urandom);
            if (low_left > 0) begin
                low_left--;
                if (low_left == 0) en = 1'b1;
            end else if ($urandom_range(0, 2999) == 0) begin
                en = 1'b0;
                low_left = $urandom_range(1, 40);
            end
            tick();
            vecs++; if (dut_bus !== exp_bus) begin fails++; $display("FAIL random_cycle n=%0d h=%0d v=%0d got=%h exp=%h", n, m_h, m_v, dut_bus, exp_bus); end
        end
        en = 1'b1;
    endtask

    task automatic test_grey_crosshair();
        bit          seen = 1'b0;
        logic [23:0] want;
        sw = 4'd1;
        for (int n = 0; n < 2 * FT; n++) begin
            tick();
            if (e_fs) seen = 1'b1;
            vecs++; if (dut_bus !== exp_bus) begin fails++; $display("FAIL grey_cycle h=%0d v=%0d got=%h exp=%h", m_h, m_v, dut_bus, exp_bus); end
            if (seen && m_h >= 0 && m_h < HA && m_v < VA && m_v >= 0) begin
                want = 24'h808080;
`ifdef VTG_CROSSHAIR_EN
                if (m_h == HA / 2 || m_v == VA / 2) want = 24'hFFFFFF;
`endif
                vecs++; if (data_o !== want) begin fails++; $display("FAIL grey_pixel h=%0d v=%0d got=%h exp=%h", m_h, m_v, data_o, want); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bars_timing();
        test_pattern_switch();
        test_ramp_invert();
        test_en_abort();
        test_async_reset();
        test_random();
        test_grey_crosshair();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
